// File: rtl/adsr_envelope_gain_if.sv
// Signal bundle between the filter/MIDI side and the envelope stage.
//
// Handshake: IN_SAMPLE_READY is a one-clock strobe that marks IN_SAMPLE and
// the MIDI controls as valid on that cycle.  There is no back-pressure; the
// envelope always accepts a strobe.  OUT_SAMPLE_READY is likewise a one-clock
// strobe marking OUT_SAMPLE valid; OUT_SAMPLE holds its value between strobes.
//
// Signals:
//   IN_SAMPLE        [11:0]  filtered sample, offset binary (2048 = silence)
//   IN_SAMPLE_READY          one-clock strobe per audio sample
//   IN_PLAYING               note held
//   IN_VELOCITY      [6:0]   note velocity
//   IN_ATTACK        [6:0]   attack time (0 = fastest)
//   IN_RELEASE       [6:0]   release time (0 = fastest)
//   OUT_SAMPLE       [11:0]  enveloped sample, offset binary
//   OUT_SAMPLE_READY         one-clock strobe, OUT_SAMPLE valid
//   OUT_STATE        [1:0]   envelope state (debug / status)
//   OUT_LEVEL        [15:0]  current envelope level
// Modports: master = sample/MIDI source side, slave = envelope block.
interface adsr_envelope_gain_if;
  logic [11:0] IN_SAMPLE;
  logic        IN_SAMPLE_READY;
  logic        IN_PLAYING;
  logic [6:0]  IN_VELOCITY;
  logic [6:0]  IN_ATTACK;
  logic [6:0]  IN_RELEASE;
  logic [11:0] OUT_SAMPLE;
  logic        OUT_SAMPLE_READY;
  logic [1:0]  OUT_STATE;
  logic [15:0] OUT_LEVEL;

  modport master (
    output IN_SAMPLE, IN_SAMPLE_READY, IN_PLAYING, IN_VELOCITY, IN_ATTACK, IN_RELEASE,
    input  OUT_SAMPLE, OUT_SAMPLE_READY, OUT_STATE, OUT_LEVEL
  );

  modport slave (
    input  IN_SAMPLE, IN_SAMPLE_READY, IN_PLAYING, IN_VELOCITY, IN_ATTACK, IN_RELEASE,
    output OUT_SAMPLE, OUT_SAMPLE_READY, OUT_STATE, OUT_LEVEL
  );
endinterface

// File: rtl/adsr_envelope_gain.sv
// Attack/sustain/release amplitude envelope for one synth voice.
// Scales each offset-binary sample around mid-scale 2048 by a 16-bit
// envelope level.  The envelope advances once per input sample strobe.
//
// Ports:
//   IN_CLOCK   system clock (single domain)
//   IN_RESET   asynchronous, active-high reset
//   bus        adsr_envelope_gain_if.slave: sample stream in/out, MIDI
//              controls, and the FSM state / level as status outputs
// Parameter:
//   STEP_SHIFT left shift applied to the per-sample attack/release step
module adsr_envelope_gain #(
  parameter int STEP_SHIFT = 2
) (
  input  logic IN_CLOCK,
  input  logic IN_RESET,
  adsr_envelope_gain_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } envState_t;

  envState_t          state;
  envState_t          nextState;
  logic        [15:0] level;
  logic        [15:0] nextLevel;

  logic        [15:0] target;
  logic        [16:0] attackStep;
  logic        [16:0] releaseStep;
  logic        [16:0] attackSum;
  logic        [15:0] attackSat;
  logic               releaseEnds;
  logic        [15:0] releaseDec;

  logic signed [12:0] centeredSample;
  logic               sampleValid;
  logic signed [29:0] product;
  logic        [11:0] scaledLow;
  logic        [11:0] outSample;
  logic               outReady;

  // Velocity is replicated so that 127 maps to full scale 0xFFFF and 0 to 0.
  assign target      = {bus.IN_VELOCITY, bus.IN_VELOCITY, bus.IN_VELOCITY[6:5]};
  assign attackStep  = {9'd0, 8'd128 - {1'b0, bus.IN_ATTACK}} << STEP_SHIFT;
  assign releaseStep = {9'd0, 8'd128 - {1'b0, bus.IN_RELEASE}} << STEP_SHIFT;

  // 17-bit sum so an attack step near full scale cannot wrap.
  assign attackSum   = {1'b0, level} + attackStep;
  assign attackSat   = (attackSum > {1'b0, target}) ? target : attackSum[15:0];
  assign releaseEnds = ({1'b0, level} <= releaseStep);
  assign releaseDec  = releaseEnds ? 16'd0 : (level - releaseStep[15:0]);

  always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
    if (IN_RESET) begin
      state <= ST_IDLE;
      level <= 16'd0;
    end else begin
      state <= nextState;
      level <= nextLevel;
    end
  end

  // Everything holds except on strobe cycles.
  always_comb begin
    nextState = state;
    nextLevel = level;
    if (bus.IN_SAMPLE_READY) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.IN_PLAYING) begin
            nextState = ST_ATTACK;
            nextLevel = attackSat;
          end
        end
        ST_ATTACK: begin
          if (!bus.IN_PLAYING) begin
            nextState = ST_RELEASE;
            nextLevel = releaseDec;
          end else if ((attackSum >= {1'b0, target}) || (level > target)) begin
            nextState = ST_SUSTAIN;
            nextLevel = target;
          end else begin
            nextLevel = attackSum[15:0];
          end
        end
        ST_SUSTAIN: begin
          if (!bus.IN_PLAYING) begin
            nextState = ST_RELEASE;
            nextLevel = releaseDec;
          end else begin
            // Track the target so velocity changes during sustain are followed.
            nextLevel = target;
          end
        end
        ST_RELEASE: begin
          if (bus.IN_PLAYING) begin
            // Legato retrigger: climb from wherever the release had reached.
            nextState = ST_ATTACK;
            nextLevel = attackSat;
          end else if (releaseEnds) begin
            nextState = ST_IDLE;
            nextLevel = 16'd0;
          end else begin
            nextLevel = releaseDec;
          end
        end
        default: begin
          nextState = ST_IDLE;
          nextLevel = 16'd0;
        end
      endcase
    end
  end

  // Stage 2 multiplies the centred sample by the level registered on the
  // same strobe edge, so each output uses the envelope updated with it.
  assign product   = 30'(centeredSample) * 30'($signed({1'b0, level}));
  assign scaledLow = 12'(product >>> 16);

  always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
    if (IN_RESET) begin
      centeredSample <= 13'sd0;
      sampleValid    <= 1'b0;
      outSample      <= 12'd2048;
      outReady       <= 1'b0;
    end else begin
      sampleValid <= bus.IN_SAMPLE_READY;
      outReady    <= sampleValid;
      if (bus.IN_SAMPLE_READY) begin
        centeredSample <= $signed({1'b0, bus.IN_SAMPLE} - 13'd2048);
      end
      if (sampleValid) begin
        // Wraps back to offset binary; range stays 0..4094 because the
        // level is at most 0xFFFF (strictly below unity gain).
        outSample <= scaledLow + 12'd2048;
      end
    end
  end

  assign bus.OUT_SAMPLE       = outSample;
  assign bus.OUT_SAMPLE_READY = outReady;
  assign bus.OUT_STATE        = state;
  assign bus.OUT_LEVEL        = level;

endmodule

// File: tb/tb_adsr_envelope_gain.sv
module tb_adsr_envelope_gain;

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_SUSTAIN = 2;
  localparam int M_RELEASE = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  adsr_envelope_gain_if bus();

  adsr_envelope_gain #(.STEP_SHIFT(2)) dut (
    .IN_CLOCK (clk),
    .IN_RESET (rst),
    .bus      (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic monOn = 1'b0;

  // behavioural envelope model
  int mState = M_IDLE;
  int mLevel = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Apply one strobe's worth of envelope rules to the model using the
  // controls currently presented on the bus.
  task automatic modelStep();
    int vel, tgt, as, rs, playing;
    vel = int'(bus.IN_VELOCITY);
    tgt = vel * 512 + vel * 4 + vel / 32;
    as  = (128 - int'(bus.IN_ATTACK)) * 4;
    rs  = (128 - int'(bus.IN_RELEASE)) * 4;
    playing = int'(bus.IN_PLAYING);
    case (mState)
      M_IDLE: begin
        if (playing != 0) begin
          mLevel = minInt(mLevel + as, tgt);
          mState = M_ATTACK;
        end
      end
      M_ATTACK: begin
        if (playing == 0) begin
          mLevel = (mLevel - rs > 0) ? mLevel - rs : 0;
          mState = M_RELEASE;
        end else if (mLevel + as >= tgt || mLevel > tgt) begin
          mLevel = tgt;
          mState = M_SUSTAIN;
        end else begin
          mLevel = mLevel + as;
        end
      end
      M_SUSTAIN: begin
        if (playing == 0) begin
          mLevel = (mLevel - rs > 0) ? mLevel - rs : 0;
          mState = M_RELEASE;
        end else begin
          mLevel = tgt;
        end
      end
      default: begin
        if (playing != 0) begin
          mLevel = minInt(mLevel + as, tgt);
          mState = M_ATTACK;
        end else if (mLevel - rs <= 0) begin
          mLevel = 0;
          mState = M_IDLE;
        end else begin
          mLevel = mLevel - rs;
        end
      end
    endcase
  endtask

  // Expected output: floor((sample-2048) * level / 65536) + 2048
  function automatic logic [11:0] expOut(input logic [11:0] smp, input int lvl);
    longint prod, q;
    prod = longint'(int'(smp) - 2048) * longint'(lvl);
    if (prod >= 0) q = prod / 65536;
    else q = -((-prod + 65535) / 65536);
    return 12'(q + 2048);
  endfunction

  // ---------------- output monitor ----------------
  logic [1:0] hist;
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b00;
    else     hist <= {hist[0], bus.IN_SAMPLE_READY};
  end

  always @(negedge clk) begin
    if (!rst && monOn) begin
      check("ready_timing", 32'(bus.OUT_SAMPLE_READY), 32'(hist[1]));
      if (bus.OUT_SAMPLE_READY) begin
        check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("out_sample", 32'(bus.OUT_SAMPLE), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [11:0] smp, input int gap);
    @(negedge clk);
    bus.IN_SAMPLE = smp;
    bus.IN_SAMPLE_READY = 1'b1;
    modelStep();
    exp_q.push_back(expOut(smp, mLevel));
    @(negedge clk);
    bus.IN_SAMPLE_READY = 1'b0;
    check("state", 32'(bus.OUT_STATE), 32'(mState));
    check("level", 32'(bus.OUT_LEVEL), 32'(mLevel));
    repeat (gap - 1) @(negedge clk);
  endtask

  // Called at a negedge; asserts reset there and checks the reset values.
  task automatic doReset();
    rst = 1'b1;
    bus.IN_SAMPLE_READY = 1'b0;
    exp_q.delete();
    mState = M_IDLE;
    mLevel = 0;
    @(negedge clk);
    check("rst_state", 32'(bus.OUT_STATE), 32'd0);
    check("rst_level", 32'(bus.OUT_LEVEL), 32'd0);
    check("rst_sample", 32'(bus.OUT_SAMPLE), 32'd2048);
    check("rst_ready", 32'(bus.OUT_SAMPLE_READY), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    bus.IN_SAMPLE = 12'd2048;
    bus.IN_SAMPLE_READY = 1'b0;
    bus.IN_PLAYING = 1'b0;
    bus.IN_VELOCITY = 7'd0;
    bus.IN_ATTACK = 7'd0;
    bus.IN_RELEASE = 7'd0;
    repeat (2) @(negedge clk);
    doReset();
    monOn = 1'b1;

    // Attack at full velocity, fastest attack: +512 per strobe
    bus.IN_VELOCITY = 7'd127;
    bus.IN_ATTACK = 7'd0;
    bus.IN_PLAYING = 1'b1;
    strobe(12'($urandom_range(0, 4095)), 3);
    check("attack_first", 32'(bus.OUT_LEVEL), 32'd512);
    strobe(12'($urandom_range(0, 4095)), 3);
    check("attack_second", 32'(bus.OUT_LEVEL), 32'd1024);
    for (int i = 3; i <= 128; i++) strobe(12'($urandom_range(0, 4095)), 3);
    check("attack_done_level", 32'(bus.OUT_LEVEL), 32'hFFFF);
    check("attack_done_state", 32'(bus.OUT_STATE), 32'(M_SUSTAIN));

    // Full-scale extremes
    strobe(12'd4095, 3);
    check("max_sample", 32'(bus.OUT_SAMPLE), 32'd4094);
    strobe(12'd0, 3);
    check("min_sample", 32'(bus.OUT_SAMPLE), 32'd0);
    strobe(12'd2048, 3);
    check("mid_sample_full", 32'(bus.OUT_SAMPLE), 32'd2048);

    // Velocity change during sustain is followed
    bus.IN_VELOCITY = 7'd64;
    strobe(12'($urandom_range(0, 4095)), 3);
    check("sustain_vel_level", 32'(bus.OUT_LEVEL), 32'h8102);
    check("sustain_vel_state", 32'(bus.OUT_STATE), 32'(M_SUSTAIN));
    bus.IN_VELOCITY = 7'd127;
    strobe(12'($urandom_range(0, 4095)), 3);
    check("sustain_back_full", 32'(bus.OUT_LEVEL), 32'hFFFF);

    // Slowest release: -4 per strobe, 16384 strobes to silence
    bus.IN_RELEASE = 7'd127;
    bus.IN_PLAYING = 1'b0;
    strobe(12'($urandom_range(0, 4095)), 3);
    check("release_first", 32'(bus.OUT_LEVEL), 32'hFFFB);
    n = 1;
    while (bus.OUT_STATE != 2'd0 && n < 20000) begin
      strobe(12'($urandom_range(0, 4095)), 3);
      n++;
    end
    check("release_strobes", 32'(n), 32'd16384);
    check("release_idle_level", 32'(bus.OUT_LEVEL), 32'd0);
    strobe(12'($urandom_range(0, 4095)), 3);
    check("idle_silence", 32'(bus.OUT_SAMPLE), 32'd2048);

    // Legato retrigger from RELEASE at 0x4000
    bus.IN_PLAYING = 1'b1;
    bus.IN_ATTACK = 7'd0;
    for (int i = 0; i < 33; i++) strobe(12'($urandom_range(0, 4095)), 2);
    check("pre_release_level", 32'(bus.OUT_LEVEL), 32'h4200);
    bus.IN_PLAYING = 1'b0;
    bus.IN_RELEASE = 7'd0;
    strobe(12'($urandom_range(0, 4095)), 2);
    check("release_at_4000", 32'(bus.OUT_LEVEL), 32'h4000);
    bus.IN_PLAYING = 1'b1;
    bus.IN_ATTACK = 7'd64;
    strobe(12'($urandom_range(0, 4095)), 2);
    check("retrigger_state", 32'(bus.OUT_STATE), 32'(M_ATTACK));
    check("retrigger_level", 32'(bus.OUT_LEVEL), 32'h4100);
    strobe(12'd2048, 3);
    check("mid_sample_partial", 32'(bus.OUT_SAMPLE), 32'd2048);

    // Randomized controls against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) bus.IN_PLAYING = ~bus.IN_PLAYING;
      if ($urandom_range(0, 7) == 0) bus.IN_VELOCITY = 7'($urandom_range(0, 127));
      bus.IN_ATTACK = 7'($urandom_range(0, 127));
      bus.IN_RELEASE = 7'($urandom_range(0, 127));
      strobe(12'($urandom_range(0, 4095)), int'($urandom_range(2, 8)));
    end

    // Reset in the middle of a release with a sample in flight
    bus.IN_PLAYING = 1'b1;
    bus.IN_VELOCITY = 7'd127;
    bus.IN_ATTACK = 7'd0;
    n = 0;
    while (mState != M_SUSTAIN && n < 300) begin
      strobe(12'($urandom_range(0, 4095)), 2);
      n++;
    end
    check("pre_reset_sustain", 32'(bus.OUT_STATE), 32'(M_SUSTAIN));
    bus.IN_PLAYING = 1'b0;
    bus.IN_RELEASE = 7'd127;
    repeat (4) strobe(12'($urandom_range(0, 4095)), 3);
    check("pre_reset_release", 32'(bus.OUT_STATE), 32'(M_RELEASE));
    @(negedge clk);
    bus.IN_SAMPLE = 12'd4095;
    bus.IN_SAMPLE_READY = 1'b1;
    @(negedge clk);
    bus.IN_SAMPLE_READY = 1'b0;
    doReset();
    repeat (3) @(negedge clk);
    check("post_reset_sample", 32'(bus.OUT_SAMPLE), 32'd2048);

    // Pipeline keeps working after reset
    bus.IN_PLAYING = 1'b1;
    bus.IN_ATTACK = 7'($urandom_range(0, 127));
    for (int i = 0; i < 20; i++) strobe(12'($urandom_range(0, 4095)), int'($urandom_range(2, 5)));
    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    monOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
